// File: rtl/nv_mem_pkg.sv
// nv_mem_pkg: shared types and constants for nv_memory_ctrl
package nv_mem_pkg;
  typedef enum logic {NVM_IDLE, NVM_PROG} nvm_state_t;
  localparam int NVM_WRITE_CYCLES = 4;
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/nv_memory_ctrl_if.sv
// nv_memory_ctrl_if: valid/ready request bus and response signals of nv_memory_ctrl
// master = requester (bitstream security controller), slave = nv_memory_ctrl
interface nv_memory_ctrl_if import nv_mem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();
  localparam int SW = strb_width(DATA_WIDTH);
  logic                  req_valid, req_ready, req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [SW-1:0]         req_strb;
  logic [DATA_WIDTH-1:0] req_wdata, rd_data;
  logic                  rd_valid, wr_done, busy, err;
  modport master (
    output req_valid, req_we, req_addr, req_strb, req_wdata,
    input  req_ready, rd_valid, rd_data, wr_done, busy, err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_strb, req_wdata,
    output req_ready, rd_valid, rd_data, wr_done, busy, err
  );
endinterface

// File: rtl/nv_mem_array.sv
// nv_mem_array: non-volatile word store, byte-strobed write port, registered read port
// ports: clk, we/waddr/wstrb/wdata (commit), re/raddr (read), rdata (valid the cycle after re)
module nv_mem_array import nv_mem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           waddr,
  input  logic [strb_width(DATA_WIDTH)-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            re,
  input  logic [ADDR_WIDTH-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]           rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk) begin
    for (int i = 0; i < strb_width(DATA_WIDTH); i++)
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/nv_memory_ctrl.sv
// nv_memory_ctrl: valid/ready NV word store controller with multi-cycle program phase
// ports: clk, rst_n (async, active low), bus (nv_memory_ctrl_if.slave), lock (only with NVM_LOCK_EN)
// NVM_LOCK_EN: sticky lock rejects writes below LOCK_WORDS until reset
module nv_memory_ctrl import nv_mem_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int WRITE_CYCLES = NVM_WRITE_CYCLES,
  parameter int LOCK_WORDS   = 16
) (
  input logic clk,
  input logic rst_n,
`ifdef NVM_LOCK_EN
  input logic lock,
`endif
  nv_memory_ctrl_if.slave bus
);
  localparam int SW = strb_width(DATA_WIDTH);
  localparam int CW = $clog2(WRITE_CYCLES + 1);
  nvm_state_t            state, state_nx;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [SW-1:0]         p_strb;
  logic [DATA_WIDTH-1:0] p_wdata, arr_rdata;
  logic                  locked, acc, oor, lock_hit, rd_acc, wr_ok, commit, rd_zero;
`ifdef NVM_LOCK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) locked <= 1'b0;
    else locked <= locked | lock;
`else
  assign locked = 1'b0;
`endif
  assign acc      = bus.req_valid && bus.req_ready;
  assign oor      = 32'(bus.req_addr) >= DEPTH;
  assign lock_hit = locked && 32'(bus.req_addr) < LOCK_WORDS;
  assign rd_acc   = acc && !bus.req_we;
  assign wr_ok    = acc && bus.req_we && !oor && !lock_hit;
  assign commit   = state == NVM_PROG && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= NVM_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == NVM_IDLE ? (wr_ok ? NVM_PROG : NVM_IDLE) : (commit ? NVM_IDLE : NVM_PROG);
  always_comb begin
    bus.req_ready = state == NVM_IDLE;
    bus.busy      = state == NVM_PROG;
    bus.wr_done   = commit;
    bus.rd_data   = rd_zero ? '0 : arr_rdata;
  end
  // rd_zero masks the array read register after reset and for out-of-range reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt          <= '0;
      p_addr       <= '0;
      p_strb       <= '0;
      p_wdata      <= '0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
      rd_zero      <= 1'b1;
    end else begin
      cnt          <= wr_ok ? CW'(WRITE_CYCLES - 1) : (cnt != '0 ? cnt - CW'(1) : cnt);
      bus.rd_valid <= rd_acc;
      bus.err      <= acc && (oor || (bus.req_we && lock_hit));
      if (rd_acc) rd_zero <= oor;
      if (wr_ok) begin
        p_addr  <= bus.req_addr;
        p_strb  <= bus.req_strb;
        p_wdata <= bus.req_wdata;
      end
    end
  nv_mem_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (commit),
    .waddr (p_addr),
    .wstrb (p_strb),
    .wdata (p_wdata),
    .re    (rd_acc && !oor),
    .raddr (bus.req_addr),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_nv_memory_ctrl.sv
// tb_nv_memory_ctrl: directed and random checks of nv_memory_ctrl against a word-array model
module tb_nv_memory_ctrl;
  localparam int DW = 32, AW = 8, DEPTH = 200, WC = 4, LW = 16;
  logic clk = 1'b0, rst_n = 1'b0, locked_m = 1'b0;
`ifdef NVM_LOCK_EN
  logic lock = 1'b0;
`endif
  int tests = 0, fails = 0;
  logic [DW-1:0] model [DEPTH];
  always #5 clk = ~clk;
  nv_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  nv_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WRITE_CYCLES(WC), .LOCK_WORDS(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef NVM_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus.slave)
  );
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [3:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
    check({tag, "_wr_done"}, 32'(bus.wr_done), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
  endtask
  task automatic rd(input logic [AW-1:0] a);
    logic [DW-1:0] e = (int'(a) < DEPTH) ? model[a] : '0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_strb  = 4'($urandom);
    tick();
    bus.req_valid = 1'b0;
    check("rd_valid", 32'(bus.rd_valid), 1);
    check("rd_data", bus.rd_data, e);
    check("rd_err", 32'(bus.err), 32'(int'(a) >= DEPTH));
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, input bit hold);
    bit ok = int'(a) < DEPTH && !(locked_m && int'(a) < LW);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_strb  = s;
    tick();
    if (!ok) begin
      bus.req_valid = 1'b0;
      check("wr_rej_err", 32'(bus.err), 1);
      check("wr_rej_busy", 32'(bus.busy), 0);
      check("wr_rej_ready", 32'(bus.req_ready), 1);
      check("wr_rej_done", 32'(bus.wr_done), 0);
      return;
    end
    if (hold) bus.req_we = 1'b0;
    else bus.req_valid = 1'b0;
    check("wr_err", 32'(bus.err), 0);
    for (int i = 1; i <= WC; i++) begin
      check("prog_ready", 32'(bus.req_ready), 0);
      check("prog_busy", 32'(bus.busy), 1);
      check("prog_done", 32'(bus.wr_done), 32'(i == WC));
      check("prog_rd_valid", 32'(bus.rd_valid), 0);
      tick();
    end
    model[a] = merge(model[a], d, s);
    check("post_ready", 32'(bus.req_ready), 1);
    check("post_busy", 32'(bus.busy), 0);
    check("post_done", 32'(bus.wr_done), 0);
    if (hold) begin
      tick();
      bus.req_valid = 1'b0;
      check("held_rd_valid", 32'(bus.rd_valid), 1);
      check("held_rd_data", bus.rd_data, model[a]);
    end
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_strb  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(8'd5);
    check("rd5_const", bus.rd_data, 32'h0);
    check("rd5_ready", 32'(bus.req_ready), 1);
    tick();
    check("rd_valid_drop", 32'(bus.rd_valid), 0);
    check("rd_data_held", bus.rd_data, 32'h0);
    wr(8'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(8'd5);
    check("rd5_full", bus.rd_data, 32'hDEADBEEF);
    wr(8'd5, 32'h11223344, 4'b0101, 1'b1);
    check("rd5_partial", bus.rd_data, 32'hDE22BE44);
    rd(8'd5);
    rd(8'd5);
    wr(8'd5, 32'hFFFFFFFF, 4'h0, 1'b1);
    check("rd5_nostrb", bus.rd_data, 32'hDE22BE44);
    wr(8'd200, 32'h12345678, 4'hF, 1'b0);
    rd(8'd250);
    check("rd250_zero", bus.rd_data, 32'h0);
    rd(8'd199);
    wr(8'd7, 32'hA5A5A5A5, 4'hF, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'd7;
    bus.req_wdata = 32'h12345678;
    bus.req_strb  = 4'hF;
    tick();
    bus.req_valid = 1'b0;
    check("abort_busy", 32'(bus.busy), 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(8'd7);
    check("rd7_kept", bus.rd_data, 32'hA5A5A5A5);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        rd(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 0) begin
          tick();
          check("rnd_rd_drop", 32'(bus.rd_valid), 0);
        end
      end else
        wr(8'($urandom_range(0, 219)), $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
    end
`ifdef NVM_LOCK_EN
    lock = 1'b1;
    tick();
    lock = 1'b0;
    locked_m = 1'b1;
    wr(8'd3, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(8'd3);
    wr(8'd16, 32'h0BADC0DE, 4'hF, 1'b1);
    check("lock16", bus.rd_data, 32'h0BADC0DE);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    locked_m = 1'b0;
    tick();
    wr(8'd3, 32'hCAFEF00D, 4'hF, 1'b1);
    check("unlock3", bus.rd_data, 32'hCAFEF00D);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
